// File: rtl/stage4_issue_queue_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : stage4_issue_queue_ctrl_pkg
// Purpose  : Shared types for the decode-to-execute issue queue.
//            - issue_q_state_t : issue controller state (ISSUE / VSET_WAIT)
//            - issue_q_meta_t  : per-entry PC and vsetvl flag
//            - issue_q_entry_t : full entry at the default payload width
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package stage4_issue_queue_ctrl_pkg;

  localparam int unsigned c_PC_W       = 32;
  localparam int unsigned c_DEF_DATA_W = 64;

  typedef logic [c_PC_W-1:0] word_t;

  typedef enum logic [0:0] {
    ISSUE     = 1'b0,
    VSET_WAIT = 1'b1
  } issue_q_state_t;

  // The payload width is a per-instance parameter, so the queue stores
  // {data, meta} as a flat vector and uses this struct for the fixed part.
  typedef struct packed {
    word_t pc;
    logic  vsetvl;
  } issue_q_meta_t;

  // Complete entry at the default payload width.
  typedef struct packed {
    logic [c_DEF_DATA_W-1:0] data;
    word_t                   pc;
    logic                    vsetvl;
  } issue_q_entry_t;

  // Stored entry width for a given payload width.
  function automatic int unsigned issue_q_entry_w(input int unsigned data_w);
    return data_w + $bits(issue_q_meta_t);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stage4_issue_queue_ctrl_issue_q_fifo.sv
//------------------------------------------------------------------------------
// Module   : stage4_issue_queue_ctrl_issue_q_fifo
// Purpose  : Circular FIFO storage for the issue queue (issue_q_fifo).
//            Storage, head/tail pointers, occupancy count, full/empty.
// Ports    : CLK, nRST        - clock, async active-low reset
//            push, pop        - write at tail / advance head (self-gated)
//            clear            - synchronous empty, beats push/pop
//            wdata / rdata    - entry written / entry at head
//            count            - occupancy, $clog2(DEPTH)+1 bits
//            full, empty      - occupancy flags
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stage4_issue_queue_ctrl_issue_q_fifo #(
  parameter int DEPTH = 4,     // power of two, >= 2
  parameter int WIDTH = 97
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic               full,
  output logic               empty
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign full  = (r_count == c_DEPTH_CNT);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_head];

  // Never write into a full queue nor read an empty one; clear beats both.
  assign w_push = push && !full  && !clear;
  assign w_pop  = pop  && !empty && !clear;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: contents are only observed with count != 0.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_tail] <= wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stage4_issue_queue_ctrl.sv
//------------------------------------------------------------------------------
// Module   : stage4_issue_queue_ctrl
// Purpose  : Decode-to-execute issue queue controller. Buffers decoded
//            packets in order, issues the head under stall/flush, and
//            serializes vector configuration: after a vsetvl issues, nothing
//            else issues until execute pulses vset_done.
// Ports    : CLK, nRST                     - clock, async active-low reset
//            enq_valid/data/pc/vsetvl      - entry from decode
//            full                          - queue full, decode must stall
//            deq_valid/ready/data/pc/vsetvl- head entry to execute
//            stall, flush                  - hazard-unit queue controls
//            vset_done                     - vsetvl committed in execute
//            vset_pending                  - waiting for vset_done
//            count                         - occupancy
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stage4_issue_queue_ctrl
  import stage4_issue_queue_ctrl_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   enq_valid,
  input  logic [DATA_W-1:0]      enq_data,
  input  logic [31:0]            enq_pc,
  input  logic                   enq_vsetvl,
  output logic                   full,
  output logic                   deq_valid,
  input  logic                   deq_ready,
  output logic [DATA_W-1:0]      deq_data,
  output logic [31:0]            deq_pc,
  output logic                   deq_vsetvl,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   vset_done,
  output logic                   vset_pending,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_ENTRY_W = int'(issue_q_entry_w(DATA_W));

  issue_q_state_t       r_state;
  issue_q_state_t       w_state_next;
  issue_q_meta_t        w_wr_meta;
  issue_q_meta_t        w_rd_meta;
  logic [c_ENTRY_W-1:0] w_wr_entry;
  logic [c_ENTRY_W-1:0] w_rd_entry;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;

  assign w_wr_meta  = '{pc: enq_pc, vsetvl: enq_vsetvl};
  assign w_wr_entry = {enq_data, w_wr_meta};

  assign deq_data   = w_rd_entry[c_ENTRY_W-1 -: DATA_W];
  assign w_rd_meta  = w_rd_entry[$bits(issue_q_meta_t)-1:0];
  assign deq_pc     = w_rd_meta.pc;
  assign deq_vsetvl = w_rd_meta.vsetvl;

  // deq_valid deliberately ignores flush: the hazard unit blocks execute
  // from consuming in a flush cycle, and the pop is suppressed here anyway.
  assign deq_valid    = !w_empty && !stall && (r_state == ISSUE);
  assign w_push       = enq_valid && !full && !flush;
  assign w_pop        = deq_valid && deq_ready && !flush;
  assign vset_pending = (r_state == VSET_WAIT);

  stage4_issue_queue_ctrl_issue_q_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_ENTRY_W)
  ) u_fifo (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (w_push),
    .pop   (w_pop),
    .clear (flush),
    .wdata (w_wr_entry),
    .rdata (w_rd_entry),
    .count (count),
    .full  (full),
    .empty (w_empty)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ISSUE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // vset_done outside VSET_WAIT has no effect.
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ISSUE;
    end else begin
      case (r_state)
        ISSUE:     if (w_pop && deq_vsetvl) w_state_next = VSET_WAIT;
        VSET_WAIT: if (vset_done)           w_state_next = ISSUE;
        default:                            w_state_next = ISSUE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Decode is expected to stall on full; a dropped entry is a protocol error.
  always @(posedge CLK) begin
    if (nRST && !flush) begin
      assert (!(enq_valid && full))
        else $warning("issue queue: enqueue while full, entry dropped");
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/stage4_issue_queue_ctrl.md
Name: stage4_issue_queue_ctrl

Overview:
- Controller and buffer for the decode-to-execute instruction queue in the 4-stage pipeline.
- Accepts decoded packets from decode, holds them in a circular FIFO, and issues them in order to execute under hazard-unit stall and flush.
- Serializes vector configuration: after a vsetvl packet issues, nothing further issues until execute reports the new vector configuration resolved.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- DATA_W, 64, width of the opaque decoded-instruction payload.

Ports:
- CLK  input  1  clock.
- nRST  input  1  reset, asynchronous, active-low.
- enq_valid  input  1  decode writes an entry (hazard-unit queue_wen).
- enq_data  input  DATA_W  decoded payload.
- enq_pc  input  32  PC of the entry (word_t).
- enq_vsetvl  input  1  entry is vsetvl/vsetvli (vsetvl_dec).
- full  output  1  queue full (is_queue_full).
- deq_valid  output  1  head entry offered to execute this cycle.
- deq_ready  input  1  execute accepts the head.
- deq_data  output  DATA_W  head payload.
- deq_pc  output  32  head PC.
- deq_vsetvl  output  1  head is vsetvl.
- stall  input  1  stall_queue from hazard unit.
- flush  input  1  flush_queue from hazard unit.
- vset_done  input  1  one-cycle pulse from execute: vsetvl result committed.
- vset_pending  output  1  controller is in VSET_WAIT.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (nRST low, async): head=0, tail=0, count=0, state=ISSUE; full=0, deq_valid=0, vset_pending=0. deq_data, deq_pc and deq_vsetvl are don't-care while deq_valid=0.
- Storage: DEPTH entries of {data, pc, vsetvl}. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- full = (count == DEPTH). This is combinational from registered count; there is no same-cycle bypass from dequeue.
- Enqueue fires when enq_valid && !full && !flush. The entry is written at tail, tail increments, and the entry is visible no earlier than the next cycle (1-cycle minimum latency, no enq-to-deq bypass).
- Enqueue attempt while full is dropped. Decode must stall on full; an assertion flags any violation.
- deq_valid = (count != 0) && !stall && state==ISSUE.
- Dequeue fires when deq_valid && deq_ready: head increments.
- deq_data, deq_pc and deq_vsetvl always present the head entry.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. This is legal at any count except 0 (no bypass) and DEPTH (enqueue blocked).
- State machine:
  - ISSUE to VSET_WAIT: dequeue fires with deq_vsetvl=1.
  - VSET_WAIT to ISSUE: vset_done=1. deq_valid can assert from the following cycle.
  - Any state to ISSUE: flush.
- vset_done while in ISSUE is ignored.
- In VSET_WAIT, enqueues continue normally until full.
- vset_pending = (state == VSET_WAIT).
- Flush (synchronous, highest priority): count=0, head=tail=0, state=ISSUE next cycle.
  - Same-cycle enqueue and dequeue are suppressed.
  - deq_valid is still computed from pre-flush state in the flush cycle. The hazard unit also asserts ex stall/flush, so execute must not consume it.
- Flush and stall together: flush wins.
- Stall: no dequeue, deq_valid=0. Enqueue still allowed, state unaffected.
- Reset asserted mid-operation: immediate return to reset values. In-flight vsetvl wait is abandoned.

Decomposition:
- rv32i_types_pkg (or the stage4 package) gains:
  - issue_q_entry_t struct {data, pc, vsetvl}.
  - issue_q_state_t enum {ISSUE, VSET_WAIT}.
- One natural sub-module: issue_q_fifo (parameterized storage, pointers, count, full/empty).
- stage4_issue_queue_ctrl instantiates issue_q_fifo and adds the issue gating and vsetvl FSM.

Test Plan:
- Reset then fill: DEPTH=4, enqueue PCs 0x100, 0x104, 0x108, 0x10C with deq_ready=0 -> count=4, full=1. A 5th enqueue of 0x110 is dropped; count stays 4.
- Drain in order: from full, deq_ready=1 for 4 cycles -> deq_pc sequence 0x100, 0x104, 0x108, 0x10C, then deq_valid=0, count=0.
- Wrap and concurrency: steady enqueue plus dequeue each cycle for 10 cycles starting with count=2 -> count constant 2, PCs in order across pointer wrap.
- vsetvl serialization: queue {0x200 vsetvl, 0x204}. Dequeue 0x200 -> vset_pending=1 and deq_valid=0 for 3 cycles. vset_done pulse -> next cycle deq_valid=1 with deq_pc=0x204.
- Flush: count=3, state=VSET_WAIT, flush with enq_valid=1 same cycle -> next cycle count=0, vset_pending=0, deq_valid=0. An enqueue of 0x300 afterwards issues with deq_pc=0x300.
- Stall and async reset: stall=1 with count=2 -> deq_valid=0, enqueue still raises count to 3. Drop nRST mid-cycle -> count=0 and full=0 immediately, without waiting for a clock edge.
